// File: rtl/sonic_cmd_resp_wr_if.sv
// sonic_cmd_resp_wr_if: command-response handshake and TX-stream signals of the response writer
interface sonic_cmd_resp_wr_if #(
    parameter int SEQ_WIDTH = 16
);
    logic [63:0]          cmd_base_rc;
    logic                 cmd_3dw_rcadd;
    logic                 init;
    logic [31:0]          cmd_type;
    logic [15:0]          requester_id;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_status;
    logic [31:0]          resp_data;
    logic                 resp_drop;
    logic                 tx_req;
    logic                 tx_ack;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [63:0]          tx_data;
    logic                 tx_sop;
    logic                 tx_eop;
    logic                 busy;
    logic [SEQ_WIDTH-1:0] resp_seq;
    modport slave (
        input  cmd_base_rc, cmd_3dw_rcadd, init, cmd_type, requester_id,
        input  resp_valid, resp_status, resp_data, tx_ack, tx_ready,
        output resp_ready, resp_drop, tx_req, tx_valid, tx_data, tx_sop, tx_eop, busy, resp_seq
    );
    modport master (
        output cmd_base_rc, cmd_3dw_rcadd, init, cmd_type, requester_id,
        output resp_valid, resp_status, resp_data, tx_ack, tx_ready,
        input  resp_ready, resp_drop, tx_req, tx_valid, tx_data, tx_sop, tx_eop, busy, resp_seq
    );
endinterface

// File: rtl/sonic_cmd_resp_wr.sv
// sonic_cmd_resp_wr: posts a 4-DW response record to host memory as a PCIe MWr TLP in 64-bit beats
module sonic_cmd_resp_wr #(
    parameter logic [7:0] REQ_TAG   = 8'h00,
    parameter int         SEQ_WIDTH = 16
) (
    input logic                clk_in,
    input logic                rst,
    sonic_cmd_resp_wr_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, HDR0, HDR1, DAT0, DAT1} state_t;
    state_t               r_state;
    logic [63:0]          r_addr;
    logic [63:0]          r_tx_data;
    logic                 r_3dw;
    logic                 r_tx_req;
    logic                 r_tx_valid;
    logic                 r_sop;
    logic                 r_eop;
    logic                 r_resp_ready;
    logic                 r_resp_drop;
    logic [31:0]          r_type;
    logic [31:0]          r_status;
    logic [31:0]          r_data;
    logic [15:0]          r_rid;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic                 w_beat_ok;
    logic                 w_take;
    logic                 w_reject;
    assign w_beat_ok = r_tx_valid && bus.tx_ready;
    // r_resp_ready still high means the engine has not yet seen the previous handshake
    assign w_take    = (r_state == IDLE) && bus.resp_valid && !r_resp_ready;
    assign w_reject  = bus.init || (bus.cmd_base_rc == 64'h0);
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_tx_data    <= '0;
            r_3dw        <= 1'b0;
            r_tx_req     <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_resp_ready <= 1'b0;
            r_resp_drop  <= 1'b0;
            r_type       <= '0;
            r_status     <= '0;
            r_data       <= '0;
            r_rid        <= '0;
            r_seq        <= '0;
        end else begin
            r_resp_ready <= w_take;
            r_resp_drop  <= w_take && w_reject;
            case (r_state)
                IDLE: if (w_take && !w_reject) begin
                    r_state  <= REQ;
                    r_tx_req <= 1'b1;
                    r_addr   <= bus.cmd_base_rc;
                    r_3dw    <= bus.cmd_3dw_rcadd;
                    r_type   <= bus.cmd_type;
                    r_status <= bus.resp_status;
                    r_data   <= bus.resp_data;
                    r_rid    <= bus.requester_id;
                end
                REQ: if (bus.tx_ack) begin
                    r_state    <= HDR0;
                    r_tx_req   <= 1'b0;
                    r_tx_valid <= 1'b1;
                    r_sop      <= 1'b1;
                    r_tx_data  <= {r_rid, REQ_TAG, 8'hFF, r_3dw ? 32'h4000_0004 : 32'h6000_0004};
                end
                HDR0: if (w_beat_ok) begin
                    r_state   <= HDR1;
                    r_sop     <= 1'b0;
                    // 3DW header pads the upper DW so the payload stays qword aligned
                    r_tx_data <= r_3dw ? {32'h0, r_addr[31:0]} : {r_addr[31:0], r_addr[63:32]};
                end
                HDR1: if (w_beat_ok) begin
                    r_state   <= DAT0;
                    r_tx_data <= {r_status, r_type};
                end
                DAT0: if (w_beat_ok) begin
                    r_state   <= DAT1;
                    r_eop     <= 1'b1;
                    r_tx_data <= {{(32-SEQ_WIDTH){1'b0}}, r_seq, r_data};
                end
                DAT1: if (w_beat_ok) begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                    r_eop      <= 1'b0;
                    r_tx_data  <= '0;
                    r_seq      <= r_seq + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign bus.resp_ready = r_resp_ready;
    assign bus.resp_drop  = r_resp_drop;
    assign bus.tx_req     = r_tx_req;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_sop     = r_sop;
    assign bus.tx_eop     = r_eop;
    assign bus.busy       = r_state != IDLE;
    assign bus.resp_seq   = r_seq;
endmodule

// File: tb/tb_sonic_cmd_resp_wr.sv
// tb_sonic_cmd_resp_wr: scoreboard bench for the response writer; a 4-bit-sequence twin exercises counter wrap
module tb_sonic_cmd_resp_wr;
    localparam logic [15:0] RID = 16'hA5C3;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] cmd_base_rc = '0;
    logic        cmd_3dw_rcadd = 1'b0;
    logic        init = 1'b1;
    logic [31:0] cmd_type = '0;
    logic [31:0] resp_status = '0;
    logic [31:0] resp_data = '0;
    logic [15:0] requester_id = RID;
    logic        resp_valid = 1'b0;
    logic        tx_ready = 1'b1;
    int          n_chk = 0;
    int          n_fail = 0;
    int          beats_acc = 0;
    logic [65:0] q[$];
    logic [3:0]  q4[$];
    logic [15:0] exp_seq = '0;
    logic [3:0]  exp_seq4 = '0;

    always #5 clk_in = ~clk_in;

    sonic_cmd_resp_wr_if #(.SEQ_WIDTH(16)) bus16 ();
    sonic_cmd_resp_wr_if #(.SEQ_WIDTH(4))  bus4 ();

    assign bus16.cmd_base_rc   = cmd_base_rc;
    assign bus16.cmd_3dw_rcadd = cmd_3dw_rcadd;
    assign bus16.init          = init;
    assign bus16.cmd_type      = cmd_type;
    assign bus16.requester_id  = requester_id;
    assign bus16.resp_valid    = resp_valid;
    assign bus16.resp_status   = resp_status;
    assign bus16.resp_data     = resp_data;
    assign bus16.tx_ready      = tx_ready;
    assign bus16.tx_ack        = bus16.tx_req;
    assign bus4.cmd_base_rc    = cmd_base_rc;
    assign bus4.cmd_3dw_rcadd  = cmd_3dw_rcadd;
    assign bus4.init           = init;
    assign bus4.cmd_type       = cmd_type;
    assign bus4.requester_id   = requester_id;
    assign bus4.resp_valid     = resp_valid;
    assign bus4.resp_status    = resp_status;
    assign bus4.resp_data      = resp_data;
    assign bus4.tx_ready       = tx_ready;
    assign bus4.tx_ack         = bus4.tx_req;

    sonic_cmd_resp_wr #(.REQ_TAG(8'h00), .SEQ_WIDTH(16)) u_dut16 (.clk_in(clk_in), .rst(rst), .bus(bus16));
    sonic_cmd_resp_wr #(.REQ_TAG(8'h00), .SEQ_WIDTH(4))  u_dut4  (.clk_in(clk_in), .rst(rst), .bus(bus4));

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (bus16.resp_ready) break;
        end
        chk("resp_ready", bus16.resp_ready, 1);
    endtask

    task automatic offer(input logic [63:0] a, input logic d3, input logic [31:0] ty, input logic [31:0] st, input logic [31:0] dt);
        logic [3:0] s4;
        s4 = exp_seq4;
        q.push_back({2'b01, RID, 8'h00, 8'hFF, d3 ? 32'h4000_0004 : 32'h6000_0004});
        q.push_back({2'b00, d3 ? {32'h0, a[31:0]} : {a[31:0], a[63:32]}});
        q.push_back({2'b00, st, ty});
        q.push_back({2'b10, 16'h0, exp_seq, dt});
        q4.push_back(s4);
        exp_seq++;
        exp_seq4++;
        init = 1'b0;
        requester_id = RID;
        cmd_base_rc = a;
        cmd_3dw_rcadd = d3;
        cmd_type = ty;
        resp_status = st;
        resp_data = dt;
        resp_valid = 1'b1;
        wait_ready();
        chk("acc_no_drop", bus16.resp_drop, 0);
        @(posedge clk_in);
        #1;
        // scramble everything after acceptance; the packet must use the latched copies
        resp_valid = 1'b0;
        init = 1'b1;
        requester_id = ~RID;
        cmd_base_rc = ~a;
        cmd_3dw_rcadd = ~d3;
        cmd_type = ~ty;
        resp_status = ~st;
        resp_data = ~dt;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (!bus16.busy) break;
        end
        chk("idle", bus16.busy, 0);
        chk("seq", bus16.resp_seq, exp_seq);
        chk("seq4", bus4.resp_seq, exp_seq4);
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic d3, input logic [31:0] ty, input logic [31:0] st, input logic [31:0] dt);
        offer(a, d3, ty, st, dt);
        wait_idle();
    endtask

    task automatic drop_case(input logic iv, input logic [63:0] a);
        init = iv;
        cmd_base_rc = a;
        resp_valid = 1'b1;
        wait_ready();
        chk("drop", bus16.resp_drop, 1);
        chk("drop_busy", bus16.busy, 0);
        @(posedge clk_in);
        #1;
        resp_valid = 1'b0;
        @(negedge clk_in);
        chk("drop_pulse", {bus16.resp_drop, bus16.resp_ready}, 0);
        repeat (3) @(negedge clk_in);
        chk("drop_no_req", {bus16.tx_req, bus16.tx_valid, bus16.busy}, 0);
        chk("drop_seq", bus16.resp_seq, exp_seq);
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [65:0] prev;
        logic [65:0] cur;
        logic [65:0] exp;
        logic [3:0]  e4;
        logic        held;
        held = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_in);
            cur = {bus16.tx_eop, bus16.tx_sop, bus16.tx_data};
            if (rst) held = 1'b0;
            else begin
                if (held) begin
                    chk("stall_hold", cur, prev);
                    chk("stall_valid", bus16.tx_valid, 1);
                end
                held = bus16.tx_valid && !tx_ready;
                prev = cur;
                if (bus16.tx_valid && tx_ready) begin
                    beats_acc++;
                    chk("beat_pending", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        exp = q.pop_front();
                        chk("beat", cur, exp);
                    end
                end
                if (bus4.tx_valid && tx_ready && bus4.tx_eop) begin
                    chk("seq4_pending", q4.size() != 0, 1);
                    if (q4.size() != 0) begin
                        e4 = q4.pop_front();
                        chk("dat1_seq4", bus4.tx_data[63:32], {28'h0, e4});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          b0;
        logic [63:0] a;
        logic        d3;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_outs", {bus16.resp_ready, bus16.resp_drop, bus16.tx_req, bus16.tx_valid, bus16.tx_sop, bus16.tx_eop, bus16.busy}, 0);
        chk("rst_data", bus16.tx_data, 0);
        chk("rst_seq", bus16.resp_seq, 0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        init = 1'b0;
        send(64'h0000_0000_1234_5670, 1'b1, 32'h5, 32'h0, 32'hAA);
        send(64'h0000_0001_0000_0010, 1'b0, 32'h7, 32'h1, 32'h55);
        b0 = beats_acc;
        fork
            send(64'h0000_0000_8000_0020, 1'b1, 32'h9, 32'h3, 32'h1234_5678);
            begin
                for (int i = 0; i < 100 && beats_acc != b0 + 2; i++) @(posedge clk_in);
                #1;
                tx_ready = 1'b0;
                repeat (3) @(posedge clk_in);
                #1;
                tx_ready = 1'b1;
            end
        join
        chk("stall_beats", beats_acc - b0, 4);
        drop_case(1'b1, 64'h0000_0000_0000_1000);
        drop_case(1'b0, 64'h0);
        b0 = beats_acc;
        offer(64'h0000_0002_0000_0040, 1'b0, 32'h11, 32'h22, 32'h33);
        for (int i = 0; i < 50 && beats_acc != b0 + 1; i++) @(posedge clk_in);
        #1;
        rst = 1'b1;
        tx_ready = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("mid_rst_outs", {bus16.resp_ready, bus16.resp_drop, bus16.tx_req, bus16.tx_valid, bus16.tx_sop, bus16.tx_eop, bus16.busy}, 0);
        chk("mid_rst_data", bus16.tx_data, 0);
        chk("mid_rst_seq", bus16.resp_seq, 0);
        q.delete();
        q4.delete();
        exp_seq = '0;
        exp_seq4 = '0;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        send(64'h0000_0000_0000_0100, 1'b1, 32'h1, 32'h0, 32'hC0DE);
        for (int n = 0; n < 15; n++) begin
            a = {$urandom(), $urandom()} & ~64'hF;
            d3 = 1'($urandom_range(0, 1));
            if (d3) a[63:32] = '0;
            if (a == 64'h0) a = 64'h100;
            send(a, d3, $urandom(), $urandom(), $urandom());
        end
        chk("q_empty", q.size(), 0);
        chk("q4_empty", q4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
